// File: rtl/braille_answer_checker.sv
`default_nettype none
// ============================================================================
// Module      : braille_answer_checker
// Description : Debounces the learner's submit button, latches the 6-dot
//               Braille cell on the switches and compares it with the current
//               target. A wrong answer emits a one-cycle dec pulse towards the
//               attempts countdown; a right answer bumps a saturating score
//               and requests the next target. Freezes once stop is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module braille_answer_checker #(
    parameter int DEB_CYCLES = 16,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         dots,
    input  logic               submit,
    input  logic [5:0]         target,
    input  logic               target_valid,
    input  logic               stop,
    output logic               dec,
    output logic               correct,
    output logic               next_req,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               done
);

    // Counter only has to reach DEB_CYCLES-1; keep at least one bit.
    localparam int               CNT_W     = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMED     = 3'd1,
        S_CHECK     = 3'd2,
        S_HIT       = 3'd3,
        S_MISS      = 3'd4,
        S_RELEASE_H = 3'd5,
        S_RELEASE_M = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sub_s;
    logic             r_sub_db;
    logic             r_sub_db_d;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [5:0]       r_tgt_q;
    logic [5:0]       r_dots_q;
    logic             w_press;
    logic             w_score_full;

    assign w_press      = r_sub_db & ~r_sub_db_d;
    assign w_score_full = &score;

    // Two-flop synchronizer for the asynchronous pushbutton.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sub_s <= 1'b0;
        end else begin
            r_sync1 <= submit;
            r_sub_s <= r_sync1;
        end
    end

    // Debounce: the level only follows after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub_db   <= 1'b0;
            r_sub_db_d <= 1'b0;
            r_deb_cnt  <= '0;
        end else begin
            r_sub_db_d <= r_sub_db;
            if (r_sub_s == r_sub_db) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == C_CNT_MAX) begin
                r_sub_db  <= r_sub_s;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    // Answer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tgt_q  <= '0;
            r_dots_q <= '0;
            dec      <= 1'b0;
            correct  <= 1'b0;
            next_req <= 1'b0;
            score    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            // Pulses last one cycle; busy drops only on entry to ARMED.
            dec      <= 1'b0;
            correct  <= 1'b0;
            next_req <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            // MISS lets its dec pulse finish and handles stop itself.
            if (stop && (r_state != S_MISS)) begin
                r_state <= S_DONE;
                done    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (target_valid) begin
                            r_tgt_q <= target;
                            r_state <= S_ARMED;
                            busy    <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (w_press) begin
                            r_dots_q <= dots;
                            r_state  <= S_CHECK;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    S_CHECK: begin
                        if (r_dots_q == r_tgt_q) begin
                            r_state  <= S_HIT;
                            correct  <= 1'b1;
                            next_req <= 1'b1;
                            if (!w_score_full) begin
                                score <= score + 1'b1;
                            end
                        end else begin
                            r_state <= S_MISS;
                            dec     <= 1'b1;
                        end
                    end
                    S_HIT: begin
                        r_state <= S_RELEASE_H;
                    end
                    S_MISS: begin
                        if (stop) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_RELEASE_M;
                        end
                    end
                    S_RELEASE_H: begin
                        // A fresh target must be awaited after a correct answer.
                        if (!r_sub_db) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_RELEASE_M: begin
                        // Retry the same latched target once the button is released.
                        if (!r_sub_db) begin
                            r_state <= S_ARMED;
                            busy    <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_braille_answer_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_braille_answer_checker
// Description : Directed self-checking bench for braille_answer_checker with
//               a small attempts-countdown model driving stop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_braille_answer_checker;

    logic       clk;
    logic       rst;
    logic [5:0] dots;
    logic       submit;
    logic [5:0] target;
    logic       target_valid;
    logic       stop;
    logic       dec;
    logic       correct;
    logic       next_req;
    logic [7:0] score;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_dec    = 0;
    int n_cor    = 0;
    int n_nxt    = 0;
    int exp_dec  = 0;
    int exp_cor  = 0;

    // Countdown model: loads 9, decrements per dec, raises stop at zero.
    logic [3:0] cd_cnt;
    logic       cd_load;
    logic       cd_en;

    braille_answer_checker #(
        .DEB_CYCLES (4),
        .SCORE_W    (8)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .dots         (dots),
        .submit       (submit),
        .target       (target),
        .target_valid (target_valid),
        .stop         (stop),
        .dec          (dec),
        .correct      (correct),
        .next_req     (next_req),
        .score        (score),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign stop = cd_en && (cd_cnt == 4'd0);

    always @(posedge clk) begin
        if (cd_load)
            cd_cnt <= 4'd9;
        else if (dec && (cd_cnt != 4'd0))
            cd_cnt <= cd_cnt - 4'd1;
    end

    // Count pulse cycles away from the active edge.
    always @(negedge clk) begin
        if (dec)      n_dec++;
        if (correct)  n_cor++;
        if (next_req) n_nxt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold);
        submit = 1'b1;
        tick(hold);
        submit = 1'b0;
        tick(16);
    endtask

    initial begin
        rst          = 1'b1;
        dots         = 6'b0;
        submit       = 1'b0;
        target       = 6'b0;
        target_valid = 1'b0;
        cd_load      = 1'b1;
        cd_en        = 1'b0;
        tick(3);

        // Reset state
        check_eq("rst_dec",      dec,      0);
        check_eq("rst_correct",  correct,  0);
        check_eq("rst_next_req", next_req, 0);
        check_eq("rst_score",    score,    0);
        check_eq("rst_done",     done,     0);
        check_eq("rst_busy",     busy,     1);
        rst = 1'b0;
        tick(5);
        check_eq("idle_no_valid_busy", busy, 1);

        // 1: correct answer with a held button
        target       = 6'b000001;
        target_valid = 1'b1;
        tick(2);
        check_eq("t1_armed_busy", busy, 0);
        dots   = 6'b000001;
        submit = 1'b1;
        tick(10);
        target_valid = 1'b0;
        submit       = 1'b0;
        tick(16);
        exp_cor++;
        check_eq("t1_correct_cnt", n_cor, exp_cor);
        check_eq("t1_next_cnt",    n_nxt, exp_cor);
        check_eq("t1_dec_cnt",     n_dec, exp_dec);
        check_eq("t1_score",       score, 1);
        check_eq("t1_back_idle",   busy,  1);

        // 2: wrong answers, with exact press-to-dec latency
        target       = 6'b001011;
        target_valid = 1'b1;
        tick(2);
        check_eq("t2_armed_busy", busy, 0);
        dots   = 6'b001010;
        submit = 1'b1;
        tick(7);
        check_eq("t2_dec_early", dec, 0);
        tick(1);
        check_eq("t2_dec_pulse", dec, 1);
        tick(1);
        check_eq("t2_dec_single", dec, 0);
        tick(1);
        submit = 1'b0;
        tick(16);
        exp_dec++;
        check_eq("t2_dec_cnt1", n_dec, exp_dec);
        check_eq("t2_score",    score, 1);
        check_eq("t2_rearmed",  busy,  0);
        press(10);
        exp_dec++;
        check_eq("t2_dec_cnt2", n_dec, exp_dec);
        check_eq("t2_cor_cnt",  n_cor, exp_cor);

        // 3: bounce shorter than the debounce window, then a clean press
        for (int i = 0; i < 2; i++) begin
            submit = 1'b1;
            tick(2);
            submit = 1'b0;
            tick(2);
        end
        tick(16);
        check_eq("t3_bounce_dec", n_dec, exp_dec);
        check_eq("t3_bounce_cor", n_cor, exp_cor);
        dots = 6'b001011;
        press(10);
        exp_cor++;
        check_eq("t3_clean_cor", n_cor, exp_cor);
        check_eq("t3_clean_dec", n_dec, exp_dec);
        check_eq("t3_score",     score, 2);

        // 4: nine misses exhaust the countdown
        cd_load = 1'b0;
        cd_en   = 1'b1;
        dots    = 6'b000000;
        for (int i = 0; i < 9; i++) begin
            press(10);
        end
        exp_dec += 9;
        check_eq("t4_dec_cnt", n_dec, exp_dec);
        check_eq("t4_stop",    stop,  1);
        check_eq("t4_done",    done,  1);
        check_eq("t4_busy",    busy,  1);
        press(10);
        check_eq("t4_no_dec_after", n_dec, exp_dec);
        check_eq("t4_score_held",   score, 2);
        check_eq("t4_done_held",    done,  1);

        // 5: reset during CHECK suppresses the result
        cd_en   = 1'b0;
        cd_load = 1'b1;
        rst     = 1'b1;
        tick(1);
        rst          = 1'b0;
        target       = 6'b000001;
        target_valid = 1'b1;
        tick(2);
        check_eq("t5_armed", busy, 0);
        dots   = 6'b000001;
        submit = 1'b1;
        tick(7);
        rst = 1'b1;
        tick(1);
        check_eq("t5_correct", correct, 0);
        check_eq("t5_dec",     dec,     0);
        check_eq("t5_score",   score,   0);
        check_eq("t5_busy",    busy,    1);
        check_eq("t5_done",    done,    0);
        rst    = 1'b0;
        submit = 1'b0;
        tick(16);
        check_eq("t5_no_cor_later", n_cor, exp_cor);
        check_eq("t5_no_dec_later", n_dec, exp_dec);

        // 6: score saturation
        for (int i = 0; i < 255; i++) begin
            press(10);
        end
        exp_cor += 255;
        check_eq("t6_score_255", score, 255);
        check_eq("t6_cor_cnt",   n_cor, exp_cor);
        press(10);
        exp_cor++;
        check_eq("t6_cor_at_sat", n_cor, exp_cor);
        check_eq("t6_nxt_at_sat", n_nxt, exp_cor);
        check_eq("t6_score_sat",  score, 255);
        check_eq("t6_dec_none",   n_dec, exp_dec);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/braille_answer_checker.md
Name: braille_answer_checker

Overview:
- Upstream stage of the attempts countdown.
- Debounces the learner's submit button and latches the 6-dot Braille cell entered on the switches. Compares that cell with the current target pattern.
- On a wrong answer, issues a single-cycle `dec` pulse to the countdown. On a correct answer, bumps the score and requests the next pattern.
- Freezes once the countdown reports `stop`.

Parameters:
- DEB_CYCLES, 16, consecutive stable synchronized samples required before the debounced submit level changes (minimum 2).
- SCORE_W, 8, width of the saturating score counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dots  in  6  Braille cell switches, bit0 = dot1 … bit5 = dot6; level, already synchronous
- submit  in  1  raw pushbutton, asynchronous, active-high
- target  in  6  expected cell from the pattern source
- target_valid  in  1  `target` is stable and usable; sampled only in IDLE
- stop  in  1  attempts exhausted, from the countdown
- dec  out  1  one-cycle pulse per wrong answer, to the countdown's `dec` input
- correct  out  1  one-cycle pulse per right answer
- next_req  out  1  one-cycle pulse requesting a new target; coincident with `correct`
- score  out  SCORE_W  number of correct answers, saturating
- busy  out  1  high in every state except ARMED
- done  out  1  high in DONE

Behaviour:
- **Reset** (`rst`=1 at a clk edge):
  - state = IDLE
  - `dec` = `correct` = `next_req` = 0
  - `score` = 0
  - `done` = 0, `busy` = 1
  - synchronizer flops, debounced level and debounce counter all cleared
  - Reset mid-operation aborts any state at the next edge, with no pulse emitted.
- **Synchronizer:** 2-flop on `submit` → `sub_s`.
- **Debounce:**
  - If `sub_s` == `sub_db`, counter = 0.
  - Otherwise the counter increments; when it equals DEB_CYCLES−1 and `sub_s` still differs, `sub_db` <= `sub_s` and counter = 0.
  - A glitch shorter than DEB_CYCLES cycles never changes `sub_db`.
- **Press event:** `press` = `sub_db` & ~`sub_db_d` (one cycle wide).
- **FSM states:**
  - IDLE: wait for `target_valid`=1, then latch `target` into `tgt_q` and go to ARMED.
  - ARMED: on `press`, latch `dots` into `dots_q` and go to CHECK.
  - CHECK: one cycle. Go to HIT if `dots_q`==`tgt_q`, else MISS.
  - HIT: assert `correct` and `next_req` for this cycle only; `score` += 1 unless already all-ones; go to RELEASE_H.
  - MISS: assert `dec` for this cycle only; go to RELEASE_M.
  - RELEASE_H: wait for `sub_db`=0, then go to IDLE (the new target must be awaited).
  - RELEASE_M: wait for `sub_db`=0, then go to ARMED with the same `tgt_q`.
  - DONE: absorbing until `rst`. `done`=1, all pulses 0, `score` held.
- **Stop priority:**
  - `stop`=1 in any state except MISS moves to DONE at the next edge.
  - In MISS, the `dec` pulse completes, then the next state is DONE if `stop` is high at that edge.
  - A press coincident with `stop` is ignored.
- **Latency:**
  - The `press` cycle is N; CHECK is N+1; `dec`/`correct` is high in cycle N+2.
  - Raw `submit` to `press` ≈ 2 + DEB_CYCLES cycles.
- **One result per press:** a held button never produces a second result; release must be debounced before re-arming.
- **Target handling:**
  - `target` changes outside IDLE are ignored because the latched copy is used.
  - `target_valid` low in IDLE keeps the block in IDLE indefinitely.
- **All outputs** are registered; no combinational path from any input to any output.

Test Plan (DEB_CYCLES=4 for simulation):
1. Reset, then `target_valid`=1 with `target`=6'b000001. Set `dots`=6'b000001 and hold `submit` 10 cycles → `correct` and `next_req` high for exactly 1 cycle, `score`=1, `dec` never high; returns to IDLE after release.
2. `target`=6'b001011, `dots`=6'b001010, press and release → exactly one `dec` pulse, `score` unchanged, back in ARMED (`busy`=0). A second wrong press gives a second single `dec`.
3. Bounce: toggle `submit` 1,0,1,0 with each level held 2 cycles, then settle low → no `press`, no `dec`/`correct`. Then a clean 10-cycle press → exactly one result.
4. Pair with the downstream countdown (starting at 9): 9 wrong presses → countdown `stop`=1 → `done`=1 next cycle. A 10th press yields no `dec`; `score` held.
5. Assert `rst` during the CHECK cycle → no `dec`/`correct` pulse, state IDLE, `score`=0 next cycle.
6. Preload `score`=255 via 255 correct rounds (or force); one more correct answer → `correct` still pulses, `score` stays 255.
